// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Handshaked ALU. Logic, compare, rotate, add/sub and HI/LO moves
//            complete in one cycle. MULT (shift-add) and DIV (restoring) run
//            iteratively over WIDTH cycles and write the HI/LO registers.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   rising-edge clock
//   rstN      in   asynchronous active-low reset
//   in_valid  in   command valid
//   in_ready  out  block can accept a command (state == IDLE)
//   in_op     in   opcode [OPW]
//   in_a      in   operand A [WIDTH]
//   in_b      in   operand B [WIDTH]
//   out_valid out  result valid (state == DONE)
//   out_ready in   downstream accepts the result
//   result    out  result [WIDTH]
//   error     out  invalid opcode or divide by zero
//   zero      out  result == 0
//   carry     out  carry / borrow / high-product-nonzero
//   overflow  out  signed overflow (ADD/SUB only)
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [OPW-1:0] c_OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] c_OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] c_OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] c_OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] c_OP_XOR  = OPW'(4);
  localparam logic [OPW-1:0] c_OP_NOR  = OPW'(5);
  localparam logic [OPW-1:0] c_OP_NAND = OPW'(6);
  localparam logic [OPW-1:0] c_OP_XNOR = OPW'(7);
  localparam logic [OPW-1:0] c_OP_EQU  = OPW'(8);
  localparam logic [OPW-1:0] c_OP_GT   = OPW'(9);
  localparam logic [OPW-1:0] c_OP_LT   = OPW'(10);
  localparam logic [OPW-1:0] c_OP_ROR  = OPW'(11);
  localparam logic [OPW-1:0] c_OP_ROL  = OPW'(12);
  localparam logic [OPW-1:0] c_OP_MULT = OPW'(13);
  localparam logic [OPW-1:0] c_OP_DIV  = OPW'(14);
  localparam logic [OPW-1:0] c_OP_MFLO = OPW'(15);
  localparam logic [OPW-1:0] c_OP_MFHI = OPW'(16);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_m;        // multiplicand / divisor
  logic [WIDTH-1:0] r_wh;       // partial product high / running remainder
  logic [WIDTH-1:0] r_wl;       // multiplier / dividend-then-quotient
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_result;
  logic             r_error;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;

  logic             w_accept;
  logic             w_iter;
  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic             w_cry;
  logic             w_ovf;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [SW-1:0]    w_sh;
  logic [CW-1:0]    w_rsh;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // MULT and DIV with a nonzero divisor take the iterative path; a zero
  // divisor is reported immediately without touching HI/LO.
  assign w_iter = (in_op == c_OP_MULT) || ((in_op == c_OP_DIV) && (in_b != '0));

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = w_iter ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (r_cnt == CW'(1)) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ single-cycle ops
  assign w_sum = {1'b0, in_a} + {1'b0, in_b};
  assign w_dif = {1'b0, in_a} - {1'b0, in_b};
  assign w_sh  = in_b[SW-1:0];
  // ROL by s equals ROR by WIDTH-s; a right shift of {a,a} by WIDTH yields a.
  assign w_rsh = (in_op == c_OP_ROL) ? (CW'(WIDTH) - {1'b0, w_sh}) : {1'b0, w_sh};

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    w_cry = 1'b0;
    w_ovf = 1'b0;
    case (in_op)
      c_OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_cry = w_sum[WIDTH];
        w_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_res = w_dif[WIDTH-1:0];
        w_cry = w_dif[WIDTH];
        w_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_dif[WIDTH-1] != in_a[WIDTH-1]);
      end
      c_OP_AND:  w_res = in_a & in_b;
      c_OP_OR:   w_res = in_a | in_b;
      c_OP_XOR:  w_res = in_a ^ in_b;
      c_OP_NOR:  w_res = ~(in_a | in_b);
      c_OP_NAND: w_res = ~(in_a & in_b);
      c_OP_XNOR: w_res = ~(in_a ^ in_b);
      c_OP_EQU:  w_res = WIDTH'(in_a == in_b);
      c_OP_GT:   w_res = WIDTH'(in_a > in_b);
      c_OP_LT:   w_res = WIDTH'(in_a < in_b);
      c_OP_ROR,
      c_OP_ROL:  w_res = WIDTH'({in_a, in_a} >> w_rsh);
      c_OP_MULT: w_res = '0;
      c_OP_DIV:  w_err = (in_b == '0);
      c_OP_MFLO: w_res = r_lo;
      c_OP_MFHI: w_res = r_hi;
      default:   w_err = 1'b1;
    endcase
  end

  // ------------------------------------------------------ iterative step
  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_rs;
  logic             w_ge;
  logic [WIDTH-1:0] w_nh;
  logic [WIDTH-1:0] w_nl;

  // Shift-add: add multiplicand on LSB of multiplier, then shift {c,hi,lo} right.
  assign w_madd = r_wl[0] ? ({1'b0, r_wh} + {1'b0, r_m}) : {1'b0, r_wh};
  // Restoring divide: shift {rem,dividend} left, subtract divisor when it fits.
  // The remainder after subtraction is below the divisor, so WIDTH bits suffice.
  assign w_rs   = {r_wh, r_wl[WIDTH-1]};
  assign w_ge   = (w_rs >= {1'b0, r_m});

  always_comb begin
    if (r_is_div) begin
      w_nh = w_ge ? (w_rs[WIDTH-1:0] - r_m) : w_rs[WIDTH-1:0];
      w_nl = {r_wl[WIDTH-2:0], w_ge};
    end else begin
      w_nh = w_madd[WIDTH:1];
      w_nl = {w_madd[0], r_wl[WIDTH-1:1]};
    end
  end

  // ------------------------------------------------------ datapath
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_m      <= '0;
      r_wh     <= '0;
      r_wl     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_is_div <= (in_op == c_OP_DIV);
      r_m      <= in_b;
      if (w_iter) begin
        r_cnt <= CW'(WIDTH);
        r_wh  <= '0;
        r_wl  <= in_a;
      end else begin
        r_result <= w_res;
        r_error  <= w_err;
        r_zero   <= (w_res == '0);
        r_carry  <= w_cry;
        r_ovf    <= w_ovf;
      end
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - CW'(1);
      r_wh  <= w_nh;
      r_wl  <= w_nl;
      if (r_cnt == CW'(1)) begin
        r_hi     <= w_nh;
        r_lo     <= w_nl;
        r_result <= w_nl;
        r_error  <= 1'b0;
        r_zero   <= (w_nl == '0);
        r_carry  <= !r_is_div && (w_nh != '0);
        r_ovf    <= 1'b0;
      end
    end
  end

  assign result   = r_result;
  assign error    = r_error;
  assign zero     = r_zero;
  assign carry    = r_carry;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq: directed cases, randomized
//            operations against an arithmetic reference model, backpressure
//            and reset during a multiply.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
  localparam int W   = 8;
  localparam int OPW = 5;
  localparam int M   = 1 << W;

  logic           clk = 1'b0;
  logic           rstN;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;
  logic           error;
  logic           zero;
  logic           carry;
  logic           overflow;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .OPW(OPW)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .error    (error),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  int errors = 0;
  int checks = 0;

  // reference architectural state and expected outputs
  int unsigned m_hi = 0;
  int unsigned m_lo = 0;
  int unsigned e_res;
  bit          e_err, e_cry, e_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int unsigned v);
    return (v >= M/2) ? int'(v) - M : int'(v);
  endfunction

  task automatic model(input int op, input int unsigned a, input int unsigned b);
    int unsigned s, p;
    int sh, sv;
    e_res = 0; e_err = 0; e_cry = 0; e_ovf = 0;
    sh = int'(b % W);
    case (op)
      0: begin
        s = a + b; e_res = s % M; e_cry = (s >= M);
        sv = to_signed(a) + to_signed(b); e_ovf = (sv > M/2 - 1) || (sv < -(M/2));
      end
      1: begin
        e_res = (a + M - b) % M; e_cry = (a < b);
        sv = to_signed(a) - to_signed(b); e_ovf = (sv > M/2 - 1) || (sv < -(M/2));
      end
      2:  e_res = a & b;
      3:  e_res = a | b;
      4:  e_res = a ^ b;
      5:  e_res = (~(a | b)) & (M - 1);
      6:  e_res = (~(a & b)) & (M - 1);
      7:  e_res = (~(a ^ b)) & (M - 1);
      8:  e_res = (a == b) ? 1 : 0;
      9:  e_res = (a > b) ? 1 : 0;
      10: e_res = (a < b) ? 1 : 0;
      11: e_res = ((a >> sh) | (a << (W - sh))) & (M - 1);
      12: e_res = ((a << sh) | (a >> (W - sh))) & (M - 1);
      13: begin
        p = a * b; m_lo = p % M; m_hi = p / M; e_res = m_lo; e_cry = (m_hi != 0);
      end
      14: begin
        if (b == 0) e_err = 1;
        else begin m_lo = a / b; m_hi = a % b; e_res = m_lo; end
      end
      15: e_res = m_lo;
      16: e_res = m_hi;
      default: e_err = 1;
    endcase
  endtask

  // Issue one command, wait for the result, check it, optionally hold
  // out_ready low for 'hold' cycles while disturbing the inputs, then retire.
  task automatic run_op(input string tag, input int op, input int unsigned a,
                        input int unsigned b, input int hold);
    int lat, exp_lat;
    logic [W-1:0] r0;
    logic [3:0]   f0;
    exp_lat = (op == 13 || (op == 14 && b != 0)) ? W + 1 : 1;
    model(op, a, b);
    chk($sformatf("%s/ready_pre", tag), in_ready, 1);
    in_valid = 1'b1; in_op = OPW'(op); in_a = W'(a); in_b = W'(b);
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = OPW'($urandom); in_a = W'($urandom); in_b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 4*W) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s/latency", tag), lat, exp_lat);
    chk($sformatf("%s/ready_busy", tag), in_ready, 0);
    chk($sformatf("%s/result", tag), result, e_res);
    chk($sformatf("%s/error", tag), error, e_err);
    chk($sformatf("%s/zero", tag), zero, (e_res == 0));
    chk($sformatf("%s/carry", tag), carry, e_cry);
    chk($sformatf("%s/overflow", tag), overflow, e_ovf);
    r0 = result;
    f0 = {error, zero, carry, overflow};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); in_op = OPW'($urandom); in_a = W'($urandom); in_b = W'($urandom);
      @(posedge clk); #1;
      chk($sformatf("%s/hold_valid", tag), out_valid, 1);
      chk($sformatf("%s/hold_ready", tag), in_ready, 0);
      chk($sformatf("%s/hold_result", tag), result, r0);
      chk($sformatf("%s/hold_flags", tag), {error, zero, carry, overflow}, f0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("%s/retire_valid", tag), out_valid, 0);
    chk($sformatf("%s/retire_ready", tag), in_ready, 1);
  endtask

  initial begin
    int op;
    int unsigned a, b;
    rstN = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0;
    #1;
    chk("reset/out_valid", out_valid, 0);
    chk("reset/outputs", {result, error, zero, carry, overflow}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    #1;
    chk("reset/in_ready", in_ready, 1);

    // arithmetic flags
    run_op("add_7f_01", 0, 8'h7F, 8'h01, 0);
    run_op("add_ff_01", 0, 8'hFF, 8'h01, 0);
    run_op("sub_05_07", 1, 8'h05, 8'h07, 0);
    run_op("sub_80_01", 1, 8'h80, 8'h01, 0);

    // multiply / divide and HI/LO moves
    run_op("mult_200x3", 13, 200, 3, 0);
    run_op("mfhi_mult", 16, 0, 0, 0);
    run_op("mflo_mult", 15, 0, 0, 0);
    run_op("div_200_7", 14, 200, 7, 0);
    run_op("mfhi_div", 16, 0, 0, 0);
    run_op("div_by_0", 14, 5, 0, 0);
    run_op("mfhi_after_div0", 16, 0, 0, 0);

    // rotates and invalid opcode
    run_op("rol_81_1", 12, 8'h81, 1, 0);
    run_op("ror_81_9", 11, 8'h81, 9, 0);
    run_op("ror_81_0", 11, 8'h81, 0, 0);
    run_op("op20", 20, 8'h12, 8'h34, 0);

    // backpressure, then confirm no stray command was taken
    run_op("bp_add", 0, 8'h10, 8'h20, 5);
    run_op("bp_mflo", 15, 0, 0, 0);

    // randomized operations against the model
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
      a  = $urandom_range(0, M - 1);
      b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, M - 1);
      run_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, int'($urandom_range(0, 2)));
    end

    // reset in the middle of a multiply
    run_op("pre_rst_mult", 13, 250, 250, 0);
    in_valid = 1'b1; in_op = OPW'(13); in_a = 8'd200; in_b = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    chk("midrst/out_valid", out_valid, 0);
    chk("midrst/outputs", {result, error, zero, carry, overflow}, 0);
    @(negedge clk) rstN = 1'b1;
    #1;
    chk("midrst/in_ready", in_ready, 1);
    m_hi = 0; m_lo = 0;
    run_op("midrst_mfhi", 16, 0, 0, 0);
    run_op("midrst_mflo", 15, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
